// File: rtl/divider_480_pkg.sv
// Shared widths, operation encodings and FSM state encodings for the RV32M divider.
package divider_480_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_DONE = 2'b10
    } div_st_e;

    // DIV and REM (op[0]==0) are the signed flavours.
    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/divider_480_if.sv
// Request/response bundle between the execute stage and the divider.
interface divider_480_if;
    import divider_480_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );

endinterface

// File: rtl/divider_480_iter_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, restore on borrow.
module div_iter_step
    import divider_480_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] diff;
    logic            ge;

    // One extra bit above the shifted remainder keeps the borrow exact for any rem_i.
    assign diff  = {rem_i, quo_i[XLEN-1]} - {2'b00, dvs_i};
    assign ge    = !diff[XLEN+1];
    assign rem_o = ge ? diff[XLEN:0] : {rem_i[XLEN-1:0], quo_i[XLEN-1]};
    assign quo_o = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/divider_480.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: 33-cycle latency,
// 1 cycle for divide-by-zero and signed overflow; busy stalls the pipe, flush aborts.
module divider_480
    import divider_480_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    divider_480_if.slave bus
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_st_e          state_q, state_d;
    logic             rem_sel_q, rem_sel_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN:0]    rem_nxt;
    logic [XLEN-1:0]  quo_nxt;
    logic             in_signed;
    logic [XLEN-1:0]  a_abs, b_abs;
    logic             div_zero, sgn_ovf;
    logic [XLEN-1:0]  quo_fix, rem_fix;

    div_iter_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nxt),
        .quo_o (quo_nxt)
    );

    always_comb begin
        in_signed = op_is_signed(bus.op);
        a_abs     = (in_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
        b_abs     = (in_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
        div_zero  = (bus.b == '0);
        sgn_ovf   = in_signed && (bus.a == INT_MIN) && (bus.b == '1);
        quo_fix   = neg_quo_q ? -quo_nxt : quo_nxt;
        rem_fix   = neg_rem_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        unique case (state_q)
            DIV_ST_IDLE: begin
                if (bus.start) begin
                    rem_sel_d = bus.op[1];
                    neg_quo_d = in_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                    neg_rem_d = in_signed && bus.a[XLEN-1];
                    rem_d     = '0;
                    quo_d     = a_abs;
                    dvs_d     = b_abs;
                    cnt_d     = CNT_W'(XLEN);
                    if (div_zero) begin
                        state_d  = DIV_ST_DONE;
                        result_d = bus.op[1] ? bus.a : '1;
                    end else if (sgn_ovf) begin
                        state_d  = DIV_ST_DONE;
                        result_d = bus.op[1] ? '0 : INT_MIN;
                    end else begin
                        state_d  = DIV_ST_CALC;
                    end
                end
            end
            DIV_ST_CALC: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DIV_ST_DONE;
                    result_d = rem_sel_q ? rem_fix : quo_fix;
                end
            end
            DIV_ST_DONE: state_d = DIV_ST_IDLE;
            default:     state_d = DIV_ST_IDLE;
        endcase

        // A killed operation must leave no trace on the visible result.
        if (bus.flush) begin
            state_d  = DIV_ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DIV_ST_IDLE;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = (state_q != DIV_ST_IDLE);
    assign bus.done   = (state_q == DIV_ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_divider_480.sv
// Randomised and directed checks of divider_480 against an arithmetic RV32M reference.
module tb_divider_480;
    import divider_480_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    divider_480_if bus ();

    divider_480 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic sgn;
        logic want_rem;
        int   sa;
        int   sb;
        sgn      = !op[0];
        want_rem = op[1];
        sa       = $signed(a);
        sb       = $signed(b);
        if (b == 32'd0)
            return want_rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return want_rem ? 32'd0 : 32'h8000_0000;
        if (sgn)
            return want_rem ? 32'(sa % sb) : 32'(sa / sb);
        return want_rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called #1 after an edge with the divider idle; returns #1 after it is idle again.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        check_eq("busy_in_done", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check_eq("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] res;
    logic [31:0] prev;
    int          lat;
    int          done_seen;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        vecs[0] = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
        vecs[1] = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
        vecs[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4] = '{2'b00, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[5] = '{2'b10, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
        vecs[6] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy",   32'(bus.busy), 32'd0);
        check_eq("reset_done",   32'(bus.done), 32'd0);
        check_eq("reset_result", bus.result,    32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check_eq($sformatf("dir%0d_result", i), res, vecs[i].exp);
            check_eq($sformatf("dir%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // A start while busy (here a divide-by-zero) must not disturb the running DIVU.
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            bus.start = (lat == 4);
            bus.op    = (lat == 4) ? 2'b00 : 2'b01;
            bus.a     = (lat == 4) ? 32'h1234 : 32'd100;
            bus.b     = (lat == 4) ? 32'd0 : 32'd7;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check_eq("ignored_start_result",  bus.result, 32'd14);
        check_eq("ignored_start_latency", 32'(lat),   32'd33);
        @(posedge clk); #1;

        // Flush ten edges into a DIVU: idle next cycle, no done, result untouched.
        prev      = bus.result;
        done_seen = 0;
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq("flush_busy_rise", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            bus.flush = (i == 10);
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        bus.flush = 1'b0;
        check_eq("flush_busy_low", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        check_eq("flush_no_done", 32'(done_seen), 32'd0);
        check_eq("flush_result",  bus.result,     prev);

        // Reset in the middle of CALC clears every output.
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("midreset_busy",   32'(bus.busy), 32'd0);
        check_eq("midreset_done",   32'(bus.done), 32'd0);
        check_eq("midreset_result", bus.result,    32'd0);

        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          mode;
            op   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = {{28{b[31]}}, b[3:0]};
                default: ;
            endcase
            run_op(op, a, b, res, lat);
            check_eq($sformatf("rnd%0d_op%0d_%08h_%08h", n, op, a, b), res, ref_result(op, a, b));
            check_eq($sformatf("rnd%0d_latency", n), 32'(lat), 32'(ref_latency(op, a, b)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_480.md
# divider_480

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the single-cycle ALU in the execute stage. It accepts one operation per start pulse and holds the pipeline via `busy` while iterating. It returns a 32-bit quotient or remainder with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`
- `a`  in  XLEN  dividend; sampled with `start`
- `b`  in  XLEN  divisor; sampled with `start`
- `flush`  in  1  abort current operation (pipeline kill)
- `busy`  out  1  high in CALC and DONE; execute stage stalls on it
- `done`  out  1  one-cycle pulse, `result` valid
- `result`  out  XLEN  quotient (op[1]=0) or remainder (op[1]=1); holds until next `done`

## Operation
- The module has three states: IDLE, CALC, DONE.
- IDLE + `start` + !`flush`:
  - Latch `op`, the sign flags, and the magnitudes |a| and |b|. Signed ops take two's-complement abs; unsigned ops take raw values.
  - Clear the partial remainder and load counter = XLEN.
  - If `b`==0 or signed overflow, go straight to DONE. Otherwise go to CALC.
- CALC, each cycle:
  - Shift {rem,quo} left 1, then trial-subtract the divisor from rem[XLEN:0] (XLEN+1-bit subtract).
  - If non-negative, keep the difference and set quo[0]=1; else restore and set quo[0]=0.
  - Decrement the counter. After the iteration that takes it to 0, go to DONE.
- DONE: drive `result`, pulse `done`, return to IDLE the next cycle.
- Sign fixup (signed ops only), applied when loading `result`:
  - Quotient is negated iff sign(a)≠sign(b).
  - Remainder is negated iff a negative.
- Special cases (RISC-V mandated):
  - b==0: quotient = all ones (0xFFFFFFFF), remainder = a. Applies to both signed and unsigned ops.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- `start` while `busy` is ignored; no queuing.
- `flush` in any state: next state IDLE, `busy` low next cycle, no `done`, `result` unchanged.
- `flush` and `start` in the same IDLE cycle: `flush` wins, nothing accepted.
- `reset` overrides everything, including mid-CALC.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, internal registers 0.
- `start` accepted at edge T.
  - Normal case: CALC occupies cycles T+1..T+XLEN, DONE is cycle T+XLEN+1, and `done` is high for exactly that cycle. Latency is 33 cycles for XLEN=32.
  - Special case: DONE is at T+1, so latency is 1.
- `busy` rises the cycle after acceptance and falls the cycle after DONE. `done` and `busy` are both high during DONE.
- `result` is registered and changes only on entry to DONE.
- The earliest back-to-back `start` is accepted in the cycle after DONE.
- Datapath widths:
  - rem is XLEN+1 bits internally (sign/borrow bit).
  - quo and divisor are XLEN bits.
  - counter is $clog2(XLEN)+1 bits.
- `busy` and `done` come directly from the state register, with no combinational path from inputs.

## Structure
- Shared defines header gets:
  - `DIV_OP_DIV/DIVU/REM/REMU` (2-bit encodings).
  - The FSM state encodings `DIV_ST_IDLE/CALC/DONE`.
  - Reuse of the existing `XLEN` define.
- One natural sub-module: `div_iter_step`, the combinational shift/trial-subtract/restore for one iteration. It is instantiated once and driven by the state register.
- Abs-value and sign-fixup negators stay inline.

## Test plan
- DIVU a=100, b=7, start at T -> `done` at T+33, `result`=14; REMU same operands -> `result`=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> `result`=0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1).
- DIV b=0, a=0x1234 -> `done` at T+1, `result`=0xFFFFFFFF; REM b=0 -> `result`=0x1234.
- DIV a=0x80000000, b=0xFFFFFFFF -> `done` at T+1, `result`=0x80000000; REM -> 0.
- Start DIVU, assert `flush` at T+10 -> `busy` low at T+11, no `done` pulse, `result` keeps previous value. Second `start` at T+5 is ignored.
- `reset` asserted mid-CALC -> next cycle all outputs 0. Then randomized 1000 ops of all four types vs reference model: every result matches, every latency is 33 or 1.
